// File: rtl/receptor_pkg.sv
// Shared types and constants for the serial ADC capture path (receptor_adc_serial).
package receptor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      FIN  = 2'd2
   } estado_t;

   localparam int FRAME_BITS = 16;

   // Cycles from the sample tick to the listo strobe for a given sclk half-period.
   function automatic int latencia(input int div);
      return 32 * div + 2;
   endfunction

endpackage

// File: rtl/receptor_adc_serial_tick.sv
// Free-running sample-period counter; tick is high for the single cycle where the count is FS_DIV-1.
module generador_tick_fs #(
   parameter int FS_DIV = 2268
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
   localparam logic [CW-1:0] CMAX = CW'(FS_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = (cnt_q == CMAX) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CMAX);

endmodule

// File: rtl/receptor_adc_serial.sv
// Runs one 16-sclk SPI frame per sample tick and presents a left-justified sample with a listo strobe
// 32*DIV+2 cycles after the tick. Define ADC_SIGNED_CONV_EN to emit two's complement instead of offset binary.
module receptor_adc_serial
   import receptor_pkg::*;
#(
   parameter int bits     = 20,
   parameter int ADC_BITS = 12,
   parameter int DIV      = 4,
   parameter int FS_DIV   = 2268
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic            sdata,
   output logic            sclk,
   output logic            cs_n,
   output logic [bits-1:0] dato,
   output logic            listo
);

   localparam int HW = $clog2(DIV + 1);
   localparam logic [HW-1:0] HMAX = HW'(DIV - 1);
   localparam logic [4:0] NFRAME = 5'(FRAME_BITS);

   estado_t               estado_q;
   logic                  sclk_q;
   logic                  cs_n_q;
   logic [bits-1:0]       dato_q;
   logic                  listo_q;
   logic [HW-1:0]         hcnt_q;
   logic [4:0]            nbit_q;
   logic [ADC_BITS-1:0]   sr_q;
   logic [ADC_BITS-1:0]   conv_d;
   logic [bits-1:0]       dato_d;
   logic                  tick;

   generador_tick_fs #(
      .FS_DIV(FS_DIV)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   always_comb begin
`ifdef ADC_SIGNED_CONV_EN
      conv_d = {~sr_q[ADC_BITS-1], sr_q[ADC_BITS-2:0]};
`else
      conv_d = sr_q;
`endif
      dato_d = bits'(conv_d) << (bits - ADC_BITS);
   end

   // The shift register is only ADC_BITS wide: the leading pad bits of the frame fall off the top.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q <= IDLE;
         sclk_q   <= 1'b1;
         cs_n_q   <= 1'b1;
         dato_q   <= '0;
         listo_q  <= 1'b0;
         hcnt_q   <= '0;
         nbit_q   <= '0;
         sr_q     <= '0;
      end else begin
         listo_q <= 1'b0;
         case (estado_q)
            IDLE: begin
               if (tick && en) begin
                  estado_q <= CONV;
                  cs_n_q   <= 1'b0;
                  sclk_q   <= 1'b0;
                  hcnt_q   <= '0;
                  nbit_q   <= '0;
               end
            end
            CONV: begin
               // All captures done and the last high half-period has ended: close the frame.
               if (nbit_q == NFRAME && !sclk_q) begin
                  estado_q <= FIN;
                  cs_n_q   <= 1'b1;
                  sclk_q   <= 1'b1;
                  dato_q   <= dato_d;
                  listo_q  <= 1'b1;
               end else if (hcnt_q == HMAX) begin
                  hcnt_q <= '0;
                  sclk_q <= ~sclk_q;
                  if (!sclk_q) begin
                     sr_q   <= {sr_q[ADC_BITS-2:0], sdata};
                     nbit_q <= nbit_q + 5'd1;
                  end
               end else begin
                  hcnt_q <= hcnt_q + 1'b1;
               end
            end
            FIN: begin
               estado_q <= IDLE;
            end
            default: begin
               estado_q <= IDLE;
            end
         endcase
      end
   end

   assign sclk  = sclk_q;
   assign cs_n  = cs_n_q;
   assign dato  = dato_q;
   assign listo = listo_q;

endmodule
